// File: rtl/muldiv_unit.sv
// Iterative signed multiply/divide unit: MUL, MULH, DIV, REM on XLEN-bit operands.
// Latency: fixed XLEN+2 edges from the start-sampling edge to the edge that samples done.
// Backpressure: none; busy stalls the EX stage, start is ignored while busy, flush aborts.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    // Multiplicand magnitude for MUL/MULH, divisor magnitude for DIV/REM.
    logic [XLEN-1:0]   opnd_q;
    // MUL: {partial product high, multiplier shifting out}; DIV: {remainder, quotient}.
    logic [2*XLEN-1:0] acc_q;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_top;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    assign mag_a  = op_a[XLEN-1] ? (~op_a + 1'b1) : op_a;
    assign mag_b  = op_b[XLEN-1] ? (~op_b + 1'b1) : op_b;
    assign accept = (state_q == IDLE) && start && !flush;

    // One shift-add multiply step and one restoring divide step per CALC cycle.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        // Remainder never exceeds the divisor magnitude, so its MSB is always zero here.
        div_top  = acc_q[2*XLEN-2:XLEN-1];
        div_diff = {1'b0, div_top} - {1'b0, opnd_q};
        div_next = div_diff[XLEN] ? {div_top, acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Sign correction of the magnitude result; divide-by-zero quotient is forced to all-ones.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo      = acc_q[XLEN-1:0];
        rem      = acc_q[2*XLEN-1:XLEN];
        fix_val  = '0;
        case (op_q)
            2'b00:   fix_val = prod_fix[XLEN-1:0];
            2'b01:   fix_val = prod_fix[2*XLEN-1:XLEN];
            2'b10:   fix_val = (opnd_q == '0) ? '1
                             : ((sign_a_q ^ sign_b_q) ? (~quo + 1'b1) : quo);
            default: fix_val = sign_a_q ? (~rem + 1'b1) : rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything and returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)            state_d = CALC;
            CALC:    if (cnt_q == '0)      state_d = FIX;
            FIX:                           state_d = DONE;
            default:                       state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Operand capture, iteration datapath and result write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result   <= '0;
        end else if (accept) begin
            cnt_q    <= CNT_W'(XLEN - 1);
            op_q     <= op;
            sign_a_q <= op_a[XLEN-1];
            sign_b_q <= op_b[XLEN-1];
            opnd_q   <= op[1] ? mag_b : mag_a;
            acc_q    <= {{XLEN{1'b0}}, (op[1] ? mag_a : mag_b)};
        end else if (!flush) begin
            if (state_q == CALC) begin
                acc_q <= op_q[1] ? div_next : mul_next;
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            if (state_q == FIX) begin
                result <= fix_val;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus randomized traffic against a
// behavioural model (plain signed arithmetic and a countdown to the done window).
// Outputs are compared every falling edge; inputs change 1ns after the rising edge.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;

    // Behavioural model state.
    logic        m_busy   = 1'b0;
    int          m_rem    = 0;
    logic [31:0] m_pend   = '0;
    logic [31:0] m_result = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] f_op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 0;
        case (f_op)
            2'b00: p = sa * sb;
            2'b01: p = (sa * sb) >>> 32;
            2'b10: begin
                if (b == 32'd0) p = -1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = sa;
                else p = sa / sb;
            end
            default: begin
                if (b == 32'd0) p = sa;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
        endcase
        return p[31:0];
    endfunction

    // Model: accepted start opens a window of XLEN+1 further edges; the last one writes result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_rem    = 0;
            m_result = '0;
        end else if (m_busy) begin
            if (flush || m_rem == 0) begin
                m_busy = 1'b0;
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_result = m_pend;
            end
        end else if (start && !flush) begin
            m_busy = 1'b1;
            m_rem  = XLEN + 1;
            m_pend = ref_model(op, op_a, op_b);
        end
    end

    always @(posedge clk) begin
        if (done) n_done++;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", {63'd0, busy}, {63'd0, m_busy});
        check("done", {63'd0, done}, {63'd0, (m_busy && m_rem == 0)});
        check("result", {32'd0, result}, {32'd0, m_result});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; lat is the edge number (start-sampling edge = 0) that samples done high.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 80) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        int lat;
        op = o; op_a = a; op_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_next"}, {63'd0, busy}, 64'd1);
        wait_done(lat);
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_result"}, {32'd0, result}, {32'd0, exp});
        tick();
        check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'($urandom_range(0, 40)) - 32'd20;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        int nd;

        // Pin the model to hand-computed values.
        check("model_mul", {32'd0, ref_model(2'b00, -32'sd7, 32'sd6)}, 64'hFFFF_FFD6);
        check("model_mulh", {32'd0, ref_model(2'b01, 32'h8000_0000, 32'h8000_0000)}, 64'h4000_0000);
        check("model_div", {32'd0, ref_model(2'b10, -32'sd17, 32'sd5)}, 64'hFFFF_FFFD);
        check("model_rem", {32'd0, ref_model(2'b11, -32'sd17, 32'sd5)}, 64'hFFFF_FFFE);
        check("model_div0", {32'd0, ref_model(2'b10, -32'sd17, 32'd0)}, 64'hFFFF_FFFF);
        check("model_ovf", {32'd0, ref_model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF)}, 64'h8000_0000);

        // Reset state.
        tick(); tick();
        check("reset_outputs", {31'd0, busy, done, result}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(2'b00, -32'sd7, 32'sd6, 32'hFFFF_FFD6, "mul_neg");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_min");
        run_op(2'b10, -32'sd17, 32'sd5, 32'hFFFF_FFFD, "div");
        run_op(2'b11, -32'sd17, 32'sd5, 32'hFFFF_FFFE, "rem");
        run_op(2'b10, -32'sd17, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run_op(2'b11, -32'sd17, 32'd0, 32'hFFFF_FFEF, "rem_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // Flush during the tenth cycle of a DIV.
        nd = n_done;
        op = 2'b10; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();
        check("flush_no_done", 64'(n_done - nd), 64'd0);
        check("flush_result_kept", {32'd0, result}, 64'd0);
        run_op(2'b10, 32'd100, 32'd7, 32'd14, "div_after_flush");

        // start together with flush in IDLE is not accepted.
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {63'd0, busy}, 64'd0);

        // start during the done cycle is ignored; accepted on the following edge.
        op = 2'b00; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("done_cycle_latency", 64'(lat), 64'(LAT));
        start = 1'b1;
        tick();
        check("start_in_done_ignored", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        check("start_after_done", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("restart_latency", 64'(lat), 64'(LAT));
        tick();

        // Second start while busy is ignored: one done, first operation's result.
        nd = n_done;
        op = 2'b00; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b10; op_a = 32'd50; op_b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (45) tick();
        check("busy_start_single_done", 64'(n_done - nd), 64'd1);
        check("busy_start_result", {32'd0, result}, 64'd15);

        // Asynchronous reset in the middle of a MUL.
        nd = n_done;
        op = 2'b00; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {31'd0, busy, done, result}, 64'd0);
        #2 rst_n = 1'b1;
        op = 2'b01; op_a = -32'sd1; op_b = -32'sd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_after_reset", {63'd0, busy}, 64'd1);
        wait_done(lat);
        check("reset_no_done", 64'(n_done - nd), 64'd0);
        check("after_reset_latency", 64'(lat), 64'(LAT));
        check("after_reset_result", {32'd0, result}, 64'd0);
        tick();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 6000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 59) == 0);
            op    = 2'($urandom_range(0, 3));
            op_a  = pick();
            op_b  = pick();
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
